csr_unit: RTL and testbench

- Machine CSR block inside the CPU; executes csrrw/csrrs/csrrc (register and immediate forms, decoded upstream) issued from the execute stage.
- Holds the tohost register (0x51E). Its value drives the tohost output, which the ISA simulation bench polls: bit0 = done, bits[31:1] = failing test number, 0 = pass.
- Also provides the read-only 64-bit cycle and instret counters for performance measurement.

---
 rtl/csr_pkg.sv | 23 ++
 rtl/csr_counter.sv | 28 ++
 rtl/csr_unit.sv | 153 +++++++++++++++
 tb/tb_csr_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: CSR address map and csr_op encodings shared by the CSR unit.
// Revision 1.0
`default_nettype none

package csr_pkg;

    localparam logic [11:0] CSR_TOHOST   = 12'h51E;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_TIME     = 12'hC01;
    localparam logic [11:0] CSR_TIMEH    = 12'hC81;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;
    localparam logic [11:0] CSR_BP_BR    = 12'h7C0;
    localparam logic [11:0] CSR_BP_MISS  = 12'h7C1;

    localparam logic [1:0] CSR_RW = 2'b01;
    localparam logic [1:0] CSR_RS = 2'b10;
    localparam logic [1:0] CSR_RC = 2'b11;

endpackage

`default_nettype wire

// File: rtl/csr_counter.sv
// csr_counter: free-running wrap-around counter with synchronous clear and enable.
// Revision 1.0
`default_nettype none

module csr_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign value = r_count;

endmodule

`default_nettype wire

// File: rtl/csr_unit.sv
// csr_unit: machine CSR block (tohost, cycle/time/instret) with 1-cycle read latency.
// Optional branch-predictor counters at 0x7C0/0x7C1 when CSR_BP_STATS_EN is defined. Revision 1.0
`default_nettype none

module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_TOHOST = 32'h0,
    parameter int          CNT_W        = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        stall,
    input  logic        retire,
    input  logic        br_resolve,
    input  logic        br_mispredict,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        illegal,
    output logic [31:0] tohost
);

    logic [CNT_W-1:0] w_cycle;
    logic [CNT_W-1:0] w_instret;

    csr_counter #(.WIDTH(CNT_W)) u_cycle (
        .clk   (clk),
        .clr   (rst),
        .inc   (1'b1),
        .value (w_cycle)
    );

    csr_counter #(.WIDTH(CNT_W)) u_instret (
        .clk   (clk),
        .clr   (rst),
        .inc   (retire),
        .value (w_instret)
    );

`ifdef CSR_BP_STATS_EN
    logic [31:0] w_bp_br;
    logic [31:0] w_bp_miss;

    csr_counter #(.WIDTH(32)) u_bp_br (
        .clk   (clk),
        .clr   (rst),
        .inc   (br_resolve),
        .value (w_bp_br)
    );

    csr_counter #(.WIDTH(32)) u_bp_miss (
        .clk   (clk),
        .clr   (rst),
        .inc   (br_resolve && br_mispredict),
        .value (w_bp_miss)
    );
`else
    logic w_unused_bp;
    assign w_unused_bp = br_resolve ^ br_mispredict;
`endif

    logic [31:0] w_cycle_lo, w_cycle_hi, w_instret_lo, w_instret_hi;
    assign w_cycle_lo   = w_cycle[31:0];
    assign w_cycle_hi   = 32'(w_cycle >> 32);
    assign w_instret_lo = w_instret[31:0];
    assign w_instret_hi = 32'(w_instret >> 32);

    // Request captured at the accepting edge, executed at the following edge.
    logic        r_req_valid;
    logic [1:0]  r_req_op;
    logic [11:0] r_req_addr;
    logic [31:0] r_req_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_valid <= 1'b0;
            r_req_op    <= 2'b00;
            r_req_addr  <= 12'h000;
            r_req_wdata <= 32'h0;
        end else begin
            r_req_valid <= csr_en && !stall;
            if (csr_en && !stall) begin
                r_req_op    <= csr_op;
                r_req_addr  <= csr_addr;
                r_req_wdata <= csr_wdata;
            end
        end
    end

    logic        w_hit;
    logic        w_ro;
    logic        w_wr_req;
    logic        w_illegal;
    logic        w_we;
    logic [31:0] w_old;
    logic [31:0] w_new;

    always_comb begin
        w_hit = 1'b1;
        w_ro  = 1'b1;
        w_old = 32'h0;
        case (r_req_addr)
            CSR_TOHOST: begin
                w_old = tohost;
                w_ro  = 1'b0;
            end
            CSR_CYCLE, CSR_TIME:   w_old = w_cycle_lo;
            CSR_CYCLEH, CSR_TIMEH: w_old = w_cycle_hi;
            CSR_INSTRET:           w_old = w_instret_lo;
            CSR_INSTRETH:          w_old = w_instret_hi;
`ifdef CSR_BP_STATS_EN
            CSR_BP_BR:             w_old = w_bp_br;
            CSR_BP_MISS:           w_old = w_bp_miss;
`endif
            default:               w_hit = 1'b0;
        endcase

        // RS/RC with a zero mask is a pure read, legal even on read-only CSRs.
        w_wr_req  = (r_req_op == CSR_RW) || (r_req_wdata != 32'h0);
        w_illegal = !w_hit || (r_req_op == 2'b00) || (w_ro && w_wr_req);
        w_we      = r_req_valid && !w_illegal && w_wr_req && !w_ro;

        case (r_req_op)
            CSR_RW:  w_new = r_req_wdata;
            CSR_RS:  w_new = w_old | r_req_wdata;
            CSR_RC:  w_new = w_old & ~r_req_wdata;
            default: w_new = w_old;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tohost      <= RESET_TOHOST;
            rdata       <= 32'h0;
            rdata_valid <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            if (w_we) begin
                tohost <= w_new;
            end
            rdata_valid <= r_req_valid;
            illegal     <= r_req_valid && w_illegal;
            rdata       <= (r_req_valid && !w_illegal) ? w_old : 32'h0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_csr_unit.sv
// tb_csr_unit: vector table plus hand sequences for csr_unit, responses checked via a scoreboard queue.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_csr_unit;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_en = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h0;
    logic [31:0] csr_wdata = 32'h0;
    logic        stall = 1'b0;
    logic        retire = 1'b0;
    logic        br_resolve = 1'b0;
    logic        br_mispredict = 1'b0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        illegal;
    logic [31:0] tohost;

    csr_unit #(.RESET_TOHOST(32'h0), .CNT_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .csr_en        (csr_en),
        .csr_op        (csr_op),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .stall         (stall),
        .retire        (retire),
        .br_resolve    (br_resolve),
        .br_mispredict (br_mispredict),
        .rdata         (rdata),
        .rdata_valid   (rdata_valid),
        .illegal       (illegal),
        .tohost        (tohost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     rdata;
        logic            ill;
        longint unsigned due;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    exp_t            sb[$];
    exp_t            mon_e;
    vec_t            tbl[16];
    int              checks = 0;
    int              errors = 0;
    longint unsigned tb_cyc = 0;

    // Reference cycle count: edges since the last reset edge.
    always @(posedge clk) tb_cyc <= rst ? 64'd0 : tb_cyc + 64'd1;

    function automatic logic [31:0] lo32(input longint unsigned x);
        return x[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rdata_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got rdata_valid=1 (rdata=0x%0h) expected 0", rdata);
            end else begin
                mon_e = sb.pop_front();
                check("rdata", 64'(rdata), 64'(mon_e.rdata));
                check("illegal", 64'(illegal), 64'(mon_e.ill));
                check("latency", tb_cyc, mon_e.due);
            end
        end
    end

    task automatic req(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_ill, input logic stl);
        exp_t e;
        csr_en    = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
        stall     = stl;
        if (!stl) begin
            e.rdata = exp_rd;
            e.ill   = exp_ill;
            e.due   = tb_cyc + 64'd2;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        csr_en = 1'b0;
        stall  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d responses outstanding expected 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{CSR_RW, CSR_TOHOST,   32'h7,         32'h1,         1'b0};
        tbl[1]  = '{CSR_RC, CSR_TOHOST,   32'h1,         32'h7,         1'b0};
        tbl[2]  = '{CSR_RS, CSR_TOHOST,   32'h0,         32'h6,         1'b0};
        tbl[3]  = '{CSR_RC, CSR_INSTRETH, 32'h0,         32'h0,         1'b0};
        tbl[4]  = '{CSR_RS, CSR_TOHOST,   32'h30,        32'h6,         1'b0};
        tbl[5]  = '{CSR_RC, CSR_TOHOST,   32'h0,         32'h36,        1'b0};
        tbl[6]  = '{CSR_RW, CSR_TOHOST,   32'hA5A5_0000, 32'h36,        1'b0};
        tbl[7]  = '{2'b00,  CSR_TOHOST,   32'hFFFF,      32'h0,         1'b1};
        tbl[8]  = '{CSR_RS, CSR_TOHOST,   32'h0,         32'hA5A5_0000, 1'b0};
        tbl[9]  = '{CSR_RW, CSR_CYCLE,    32'h5,         32'h0,         1'b1};
        tbl[10] = '{CSR_RW, 12'h123,      32'h1,         32'h0,         1'b1};
        tbl[11] = '{CSR_RS, CSR_INSTRET,  32'h1,         32'h0,         1'b1};
        tbl[12] = '{CSR_RC, CSR_CYCLEH,   32'hF,         32'h0,         1'b1};
        tbl[13] = '{CSR_RW, CSR_TIMEH,    32'h0,         32'h0,         1'b1};
        tbl[14] = '{CSR_RW, CSR_TOHOST,   32'h6,         32'hA5A5_0000, 1'b0};
        tbl[15] = '{CSR_RS, CSR_TOHOST,   32'h0,         32'h6,         1'b0};

        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_tohost", 64'(tohost), 64'h0);
        check("reset_valid", 64'(rdata_valid), 64'h0);
        check("reset_illegal", 64'(illegal), 64'h0);
        check("reset_rdata", 64'(rdata), 64'h0);
        rst = 1'b0;
        req(CSR_RS, CSR_CYCLE, 32'h0, lo32(tb_cyc + 64'd1), 1'b0, 1'b0);

        // Write then immediate read of tohost.
        req(CSR_RW, CSR_TOHOST, 32'h1, 32'h0, 1'b0, 1'b0);
        req(CSR_RS, CSR_TOHOST, 32'h0, 32'h1, 1'b0, 1'b0);
        drain();
        check("tohost_pass", 64'(tohost), 64'h1);

        for (int i = 0; i < 16; i++)
            req(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_ill, 1'b0);
        drain();
        check("tohost_table", 64'(tohost), 64'h6);

        // Counters keep running across the illegal writes above.
        req(CSR_RS, CSR_CYCLE,  32'h0, lo32(tb_cyc + 64'd1), 1'b0, 1'b0);
        req(CSR_RC, CSR_TIME,   32'h0, lo32(tb_cyc + 64'd1), 1'b0, 1'b0);
        req(CSR_RS, CSR_CYCLEH, 32'h0, 32'h0, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 10; i++) begin
            retire = 1'b1;
            req(CSR_RS, CSR_INSTRET, 32'h0, 32'(i + 1), 1'b0, i[0]);
        end
        retire = 1'b0;
        req(CSR_RS, CSR_INSTRET,  32'h0, 32'd10, 1'b0, 1'b0);
        req(CSR_RS, CSR_INSTRETH, 32'h0, 32'h0,  1'b0, 1'b0);
        drain();

        // Preload cycle just below the 32-bit boundary, then read the high word.
        force dut.u_cycle.r_count = 64'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.u_cycle.r_count;
        @(negedge clk);
        req(CSR_RS, CSR_CYCLEH, 32'h0, 32'h1, 1'b0, 1'b0);
        drain();

        // Reset while a write is in flight: response and write are both dropped.
        csr_en    = 1'b1;
        csr_op    = CSR_RW;
        csr_addr  = CSR_TOHOST;
        csr_wdata = 32'h9;
        @(negedge clk);
        csr_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check("midreset_valid", 64'(rdata_valid), 64'h0);
        repeat (2) @(negedge clk);
        check("midreset_tohost", 64'(tohost), 64'h0);
        rst = 1'b0;
        req(CSR_RS, CSR_CYCLE,  32'h0, lo32(tb_cyc + 64'd1), 1'b0, 1'b0);
        req(CSR_RS, CSR_CYCLEH, 32'h0, 32'h0, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 4; i++) begin
            br_resolve    = 1'b1;
            br_mispredict = (i == 2);
            @(negedge clk);
        end
        br_resolve    = 1'b0;
        br_mispredict = 1'b0;
`ifdef CSR_BP_STATS_EN
        req(CSR_RS, CSR_BP_BR,   32'h0, 32'd4, 1'b0, 1'b0);
        req(CSR_RS, CSR_BP_MISS, 32'h0, 32'd1, 1'b0, 1'b0);
`else
        req(CSR_RS, CSR_BP_BR,   32'h0, 32'h0, 1'b1, 1'b0);
        req(CSR_RS, CSR_BP_MISS, 32'h0, 32'h0, 1'b1, 1'b0);
`endif
        drain();
        check("final_tohost", 64'(tohost), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
